// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi, r_lo, r_opd, r_pend, r_result;
    logic             r_neg_q, r_neg_r;

    logic             w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_ma, w_mb;
    logic             w_div0, w_ovf, w_fast;
    logic [WIDTH-1:0] w_short_res, w_fast_res;

    assign w_a_sgn = (i_op == 3'b001) | (i_op == 3'b010) |
                     (i_op == 3'b100) | (i_op == 3'b110);
    assign w_b_sgn = (i_op == 3'b001) | (i_op == 3'b100) | (i_op == 3'b110);
    assign w_a_neg = w_a_sgn & i_a[WIDTH-1];
    assign w_b_neg = w_b_sgn & i_b[WIDTH-1];
    assign w_ma    = w_a_neg ? -i_a : i_a;
    assign w_mb    = w_b_neg ? -i_b : i_b;
    assign w_div0  = i_op[2] & (i_b == '0);
    assign w_ovf   = i_op[2] & ~i_op[0] & (i_a == MIN) & (&i_b);

    always_comb begin
        w_short_res = '0;
        if (w_div0)
            w_short_res = i_op[1] ? i_a : '1;
        else if (w_ovf)
            w_short_res = i_op[1] ? '0 : i_a;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fprod, w_fprod_s;
    assign w_fprod   = {{WIDTH{1'b0}}, w_ma} * {{WIDTH{1'b0}}, w_mb};
    assign w_fprod_s = (w_a_neg ^ w_b_neg) ? -w_fprod : w_fprod;
    assign w_fast    = ~i_op[2];
    assign w_fast_res = (i_op[1:0] == 2'b00) ? w_fprod_s[WIDTH-1:0]
                                             : w_fprod_s[2*WIDTH-1:WIDTH];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // One radix-2 step; r_lo carries multiplier bits out / quotient bits in
    logic [WIDTH:0]     w_sum, w_shl, w_diff;
    logic [WIDTH-1:0]   w_hi_n, w_lo_n, w_q, w_r, w_fin;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;

    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_shl  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_opd};

    always_comb begin
        w_hi_n = w_sum[WIDTH:1];
        w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_op[2]) begin
            w_hi_n = w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_lo_n = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
        end
    end

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_q      = r_neg_q ? -w_lo_n : w_lo_n;
    assign w_r      = r_neg_r ? -w_hi_n : w_hi_n;

    always_comb begin
        w_fin = w_prod_s[2*WIDTH-1:WIDTH];
        if (r_op[2])
            w_fin = r_op[1] ? w_r : w_q;
        else if (r_op[1:0] == 2'b00)
            w_fin = w_prod_s[WIDTH-1:0];
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (i_valid && !i_flush)
                      w_next = (w_div0 | w_ovf | w_fast) ? DONE : CALC;
            CALC: if (i_flush)
                      w_next = IDLE;
                  else if (r_cnt == CW'(1))
                      w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_pend   <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (i_valid && !i_flush) begin
                    r_op    <= i_op;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_cnt   <= CW'(WIDTH);
                    r_hi    <= '0;
                    r_lo    <= i_op[2] ? w_ma : w_mb;
                    r_opd   <= i_op[2] ? w_mb : w_ma;
                    if (w_div0 | w_ovf)
                        r_pend <= w_short_res;
                    else if (w_fast)
                        r_pend <= w_fast_res;
                end
                CALC: if (i_flush) begin
                    r_cnt <= '0;
                end else begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_pend <= w_fin;
                end
                DONE: if (!i_flush)
                    r_result <= r_pend;
                default: ;
            endcase
        end
    end

    assign o_ready  = (r_state == IDLE);
    assign o_valid  = (r_state == DONE) && !i_flush;
    assign o_result = (r_state == DONE) ? r_pend : r_result;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, ovalid;
    logic [W-1:0] res;

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] last_res = '0;

    mul_div_unit #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_op(op),
        .i_a(a), .i_b(b), .i_flush(flush),
        .o_ready(ready), .o_valid(ovalid), .o_result(res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] ux, uy, up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (f)
            3'd0: begin up = ux * uy; return up[31:0]; end
            3'd1: begin sp = sx * sy; return sp[63:32]; end
            3'd2: begin sp = sx * $signed(uy); return sp[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == '0) return '1;
                if (x == MIN && y == '1) return x;
                sp = sx / sy; return sp[31:0];
            end
            3'd5: return (y == '0) ? '1 : x / y;
            3'd6: begin
                if (y == '0) return x;
                if (x == MIN && y == '1) return '0;
                sp = sx % sy; return sp[31:0];
            end
            default: return (y == '0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        if (f[2] && (y == '0 || (!f[0] && x == MIN && y == '1)))
            return 1;
        return W + 1;
    endfunction

    // Called between edges; returns just before a negedge-safe point
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input string tag);
        int lat;
        bit got;
        logic [W-1:0] e;
        e = model(f, x, y);
        check({tag, "_ready"}, ready, 1);
        valid = 1'b1; op = f; a = x; b = y;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                valid = 1'b0;
                op = 3'($urandom); a = $urandom; b = $urandom;
            end
            if (ovalid) got = 1;
        end
        check({tag, "_lat"}, lat, exp_lat(f, x, y));
        check({tag, "_res"}, res, e);
        @(posedge clk); #1;
        check({tag, "_pulse"}, ovalid, 0);
        check({tag, "_hold"}, res, e);
        last_res = e;
        @(negedge clk);
    endtask

    task automatic watch_quiet(input string tag);
        bit seen;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ovalid) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [2:0] f;
        logic [W-1:0] x, y;
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", ovalid, 0);
        check("rst_result", res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul");
        run_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, "mulh");
        run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFD, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
        run_op(3'd5, 32'd100, 32'd7, "divu");
        run_op(3'd7, 32'd100, 32'd7, "remu");
        run_op(3'd5, 32'h1234_5678, 32'd0, "divu0");
        run_op(3'd6, 32'h1234_5678, 32'd0, "rem0");
        run_op(3'd4, MIN, 32'hFFFF_FFFF, "divovf");
        run_op(3'd6, MIN, 32'hFFFF_FFFF, "removf");
`ifdef MDU_FAST_MUL_EN
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "fast_mulhu");
        run_op(3'd0, 32'd3, 32'd5, "fast_b2b");
`endif
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom; y = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) y = '0;
            else if (k == 1) begin x = MIN; y = '1; end
            else if (k == 2) y = $urandom_range(1, 15);
            else if (k == 3) x = $urandom_range(0, 100);
            run_op(f, x, y, "rnd");
        end

        // Flush in CALC
        valid = 1'b1; op = 3'd5; a = $urandom; b = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flc_ready", ready, 1);
        check("flc_hold", res, last_res);
        watch_quiet("flc_quiet");
        @(negedge clk);
        run_op(3'd0, 32'd3, 32'd5, "after_flush");

        // Flush in DONE on a latency-1 request
        valid = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = '0;
        @(posedge clk); #1;
        valid = 1'b0;
        flush = 1'b1;
        #1;
        check("fld_valid", ovalid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("fld_ready", ready, 1);
        check("fld_hold", res, last_res);
        @(negedge clk);

        // Flush in IDLE blocks acceptance
        valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        check("fli_ready", ready, 1);
        watch_quiet("fli_quiet");
        @(negedge clk);

        // Asynchronous reset mid-CALC
        valid = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", ovalid, 0);
        check("arst_ready", ready, 1);
        check("arst_result", res, 0);
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("arst_quiet");
        @(negedge clk);
        run_op(3'd5, 32'd100, 32'd7, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
